// File: rtl/p1_pkg.sv
// Shared definitions for the p1 result-accumulator slice: state encoding,
// default sizing constants and the sum/count width derivation helpers.
package p1_pkg;

    // Default ALU result width and run length.
    localparam int unsigned P1_N_DEFAULT     = 4;
    localparam int unsigned P1_DEPTH_DEFAULT = 8;

    // Controller state, 2-bit legacy-compatible encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Sample counter width for a run of 'depth' results.
    function automatic int unsigned p1_cw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Sum width wide enough for 'depth' samples of 2^n-1 without overflow.
    function automatic int unsigned p1_sw(input int unsigned n, input int unsigned depth);
        return n + $clog2(depth);
    endfunction

endpackage

// File: rtl/p1_result_accumulator_ctrl.sv
// Run controller: IDLE/RUN/DONE FSM plus the per-run sample counter.
// Produces the handshake/status outputs and the accumulator strobes.
module p1_acc_ctrl
    import p1_pkg::*;
#(
    parameter  int unsigned DEPTH = P1_DEPTH_DEFAULT,
    localparam int unsigned CW    = p1_cw(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic start_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output logic busy_o,
    output logic sum_valid_o,
    output logic acc_clr_o,
    output logic acc_en_o,
    output logic acc_last_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xfer;

    // Outputs decode the registered state only; no path from in_valid.
    assign in_ready_o  = (state_q == ST_RUN);
    assign busy_o      = (state_q != ST_IDLE);
    assign sum_valid_o = (state_q == ST_DONE);
    assign xfer        = in_valid_i && in_ready_o;

    // Next-state, counter and strobe decode; clear overrides every state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_clr_o  = 1'b0;
        acc_en_o   = 1'b0;
        acc_last_o = 1'b0;
        if (clear_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            acc_clr_o = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        acc_clr_o = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        acc_en_o = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            acc_last_o = 1'b1;
                            state_d    = ST_DONE;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/p1_result_accumulator.sv
// Sums a run of DEPTH unsigned ALU results into a widened accumulator and
// presents the final sum with a one-cycle valid pulse.
module p1_result_accumulator
    import p1_pkg::*;
#(
    parameter  int unsigned N     = P1_N_DEFAULT,
    parameter  int unsigned DEPTH = P1_DEPTH_DEFAULT,
    localparam int unsigned CW    = p1_cw(DEPTH),
    localparam int unsigned SW    = p1_sw(N, DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic [SW-1:0] sum_out,
    output logic          sum_valid,
    output logic          busy
);

    logic          acc_clr, acc_en, acc_last;
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-1:0] in_ext;

    assign in_ext  = {{CW{1'b0}}, in_data};
    assign sum_out = sum_q;

    p1_acc_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .busy_o      (busy),
        .sum_valid_o (sum_valid),
        .acc_clr_o   (acc_clr),
        .acc_en_o    (acc_en),
        .acc_last_o  (acc_last)
    );

    // Accumulator update; the final sum is captured on the last transfer so
    // it is already on sum_out during DONE and survives the next run's clear.
    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + in_ext;
        end
        if (clear) begin
            sum_d = '0;
        end else if (acc_last) begin
            sum_d = acc_q + in_ext;
        end
    end

    // Accumulator and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: tb/tb_p1_result_accumulator.sv
// Directed bench for p1_result_accumulator (N=4, DEPTH=8).
module tb_p1_result_accumulator;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SW    = 7;

    logic          clk = 1'b0;
    logic          rst, start, clear, in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready, sum_valid, busy;
    logic [SW-1:0] sum_out;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    p1_result_accumulator #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic feed(input logic [N-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    // ALU subtract opcode: result is modulo 2^N.
    function automatic logic [N-1:0] alu_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        return a - b;
    endfunction

    initial begin
        logic [N-1:0] a, b, d;
        int unsigned  exp_sum;

        rst = 1'b1; start = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;

        // Reset held two cycles with start asserted.
        tick();
        tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sum", {25'd0, sum_out}, 32'd0);
        chk("rst_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Max-value run: eight 4'hF with in_valid held high.
        start_run("max_start");
        for (int i = 0; i < 8; i++) begin
            chk("max_novalid", {31'd0, sum_valid}, 32'd0);
            feed(4'hF);
        end
        chk("max_valid", {31'd0, sum_valid}, 32'd1);
        chk("max_sum", {25'd0, sum_out}, 32'd120);
        chk("max_ready_drop", {31'd0, in_ready}, 32'd0);
        tick();
        chk("max_pulse_end", {31'd0, sum_valid}, 32'd0);
        chk("max_idle", {31'd0, busy}, 32'd0);
        chk("max_held", {25'd0, sum_out}, 32'd120);

        // Stalled run: 1..8 with a three-cycle gap after the 4th value.
        start_run("stall_start");
        for (int i = 1; i <= 4; i++) feed(N'(i));
        in_data = 4'h9;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", {31'd0, in_ready}, 32'd1);
            chk("stall_novalid", {31'd0, sum_valid}, 32'd0);
        end
        for (int i = 5; i <= 8; i++) begin
            chk("stall_not_done", {31'd0, sum_valid}, 32'd0);
            feed(N'(i));
        end
        chk("stall_valid", {31'd0, sum_valid}, 32'd1);
        chk("stall_sum", {25'd0, sum_out}, 32'd36);
        tick();

        // Abort after five transfers; the coincident transfer is dropped.
        start_run("abort_start");
        for (int i = 0; i < 5; i++) feed(4'h2);
        clear = 1'b1; in_valid = 1'b1; in_data = 4'h2;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum", {25'd0, sum_out}, 32'd0);
        chk("abort_valid", {31'd0, sum_valid}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_pulse", {31'd0, sum_valid}, 32'd0);
        end
        start_run("fresh_start");
        for (int i = 0; i < 8; i++) feed(4'h2);
        chk("fresh_valid", {31'd0, sum_valid}, 32'd1);
        chk("fresh_sum", {25'd0, sum_out}, 32'd16);
        tick();

        // Start while busy is ignored; start in DONE is not queued.
        start_run("ign_start");
        for (int i = 0; i < 3; i++) feed(4'h3);
        start = 1'b1;
        tick();
        chk("ign_run_busy", {31'd0, busy}, 32'd1);
        feed(4'h3);
        start = 1'b0;
        for (int i = 0; i < 4; i++) feed(4'h3);
        chk("ign_valid", {31'd0, sum_valid}, 32'd1);
        chk("ign_sum", {25'd0, sum_out}, 32'd24);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_start_idle", {31'd0, busy}, 32'd0);
            chk("idle_held_sum", {25'd0, sum_out}, 32'd24);
        end

        // Reset mid-run acts like clear.
        start_run("rstmid_start");
        for (int i = 0; i < 3; i++) feed(4'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_sum", {25'd0, sum_out}, 32'd0);

        // End-to-end: 100 runs of random subtract results, with random stalls.
        for (int r = 0; r < 100; r++) begin
            exp_sum = 0;
            start_run("e2e_start");
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
                a = N'($urandom);
                b = N'($urandom);
                d = alu_sub(a, b);
                exp_sum += int'(d);
                feed(d);
            end
            chk("e2e_valid", {31'd0, sum_valid}, 32'd1);
            chk("e2e_sum", {25'd0, sum_out}, exp_sum);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
